// File: rtl/sprite_line_fetch.sv
// rtl/sprite_line_fetch.sv - sprite row fetch into double line buffer with per-pixel query
//
// Purpose: during hblank, walks one sprite row through the sprite ROM and captures
// it into a back line buffer, then swaps it to the front. During active video,
// answers per-column colour/hit queries from the front buffer with 1-cycle latency.
//
// Ports:
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   start                        one-cycle pulse at start of hblank
//   line_y, sprite_y, sprite_x   next scanline, sprite top and left edges
//   flip_x                       mirror the sprite horizontally
//   rom_read_address, rom_data_in  sprite ROM port (read data 1 cycle after address)
//   busy, done                   fetch in progress / buffers just swapped
//   draw_x                       query column
//   pixel_out, pixel_hit         registered query result
module sprite_line_fetch #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter logic [23:0] TRANSPARENT = 24'h000000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [9:0]  line_y,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic        flip_x,
    output logic [9:0]  rom_read_address,
    input  logic [23:0] rom_data_in,
    output logic        busy,
    output logic        done,
    input  logic [9:0]  draw_x,
    output logic [23:0] pixel_out,
    output logic        pixel_hit
);

    localparam int          CW  = $clog2(SPRITE_W);
    localparam int          RB  = 10 - CW;
    localparam logic [10:0] H11 = 11'(SPRITE_H);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic [10:0]     row;
    logic [CW-1:0]   col;
    logic [CW-1:0]   col_d;
    logic            cap_en;
    logic            flip_l;
    logic [9:0]      x_l;
    logic            front_sel;
    logic            back_sel;
    logic [1:0]      buf_valid;
    logic [9:0]      buf_x [0:1];

    logic [23:0]         pix_mem [0:2*SPRITE_W-1];
    logic [2*SPRITE_W-1:0] opaque;

    logic [CW-1:0]   wr_idx;
    logic [10:0]     px;
    logic [CW:0]     rd_addr;
    logic            q_hit;

    assign back_sel = ~front_sel;

    // Address is only driven while fetching so the ROM sees 0 when idle.
    assign rom_read_address = (state == S_FETCH) ? {row[RB-1:0], col} : 10'd0;

    // Mirroring a power-of-two width is just bit inversion of the column.
    assign wr_idx = flip_l ? ~col_d : col_d;

    // Signed 11-bit offset; bits above CW all zero means 0 <= px < SPRITE_W.
    assign px      = {1'b0, draw_x} - {1'b0, buf_x[front_sel]};
    assign rd_addr = {front_sel, px[CW-1:0]};
    assign q_hit   = buf_valid[front_sel] && (px[10:CW] == '0) && opaque[rd_addr];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            col_d     <= '0;
            cap_en    <= 1'b0;
            flip_l    <= 1'b0;
            x_l       <= '0;
            front_sel <= 1'b0;
            buf_valid <= '0;
            buf_x[0]  <= '0;
            buf_x[1]  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Capture trails the address stream by the ROM's one-cycle latency.
            col_d  <= col;
            cap_en <= (state == S_FETCH);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row    <= {1'b0, line_y} - {1'b0, sprite_y};
                        x_l    <= sprite_x;
                        flip_l <= flip_x;
                        busy   <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!row[10] && (row < H11)) begin
                        col   <= '0;
                        state <= S_FETCH;
                    end else begin
                        buf_valid[back_sel] <= 1'b0;
                        busy                <= 1'b0;
                        done                <= 1'b1;
                        state               <= S_DONE;
                    end
                end
                S_FETCH: begin
                    col <= col + 1'b1;
                    if (col == CW'(SPRITE_W - 1))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    buf_valid[back_sel] <= 1'b1;
                    busy                <= 1'b0;
                    done                <= 1'b1;
                    state               <= S_DONE;
                end
                S_DONE: begin
                    // The sprite position travels with its buffer.
                    buf_x[back_sel] <= x_l;
                    front_sel       <= back_sel;
                    done            <= 1'b0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffer contents are gated by the valid flags, so they need no reset.
    always_ff @(posedge Clk) begin
        if (cap_en) begin
            pix_mem[{back_sel, wr_idx}] <= rom_data_in;
            opaque[{back_sel, wr_idx}]  <= (rom_data_in != TRANSPARENT);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_hit <= 1'b0;
            pixel_out <= '0;
        end else begin
            pixel_hit <= q_hit;
            pixel_out <= q_hit ? pix_mem[rd_addr] : 24'd0;
        end
    end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// tb/tb_sprite_line_fetch.sv - directed self-checking bench for sprite_line_fetch
module tb_sprite_line_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  line_y, sprite_x, sprite_y, draw_x;
    logic        flip_x;
    logic [9:0]  rom_read_address;
    logic [23:0] rom_data_in = '0;
    logic        busy, done, pixel_hit;
    logic [23:0] pixel_out;

    int checks = 0;
    int errors = 0;
    int zero_addr = -1;

    sprite_line_fetch dut (
        .Clk              (clk),
        .Reset_n          (rst_n),
        .start            (start),
        .line_y           (line_y),
        .sprite_x         (sprite_x),
        .sprite_y         (sprite_y),
        .flip_x           (flip_x),
        .rom_read_address (rom_read_address),
        .rom_data_in      (rom_data_in),
        .busy             (busy),
        .done             (done),
        .draw_x           (draw_x),
        .pixel_out        (pixel_out),
        .pixel_hit        (pixel_hit)
    );

    always #5 clk = ~clk;

    // ROM model: word = address, except one optional transparent word.
    always @(posedge clk)
        rom_data_in <= (int'(rom_read_address) == zero_addr) ? 24'd0 : {14'd0, rom_read_address};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; that half-cycle is cycle 0 with start high.
    task automatic run_fetch(input logic [9:0] ly, input logic [9:0] sy, input logic [9:0] sx,
                             input logic fx, input bit exp_hit, input int repulse_at);
        int last;
        int base;
        int exp_addr;
        base = (int'(ly) - int'(sy)) * 32;
        last = exp_hit ? 36 : 3;
        line_y = ly; sprite_y = sy; sprite_x = sx; flip_x = fx; start = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == 1 || k == repulse_at + 1) start = 1'b0;
            if (k == repulse_at) start = 1'b1;
            exp_addr = (exp_hit && k >= 2 && k <= 33) ? base + k - 2 : 0;
            check($sformatf("addr y%0d c%0d", ly, k), 32'(rom_read_address), 32'(exp_addr));
            check($sformatf("busy y%0d c%0d", ly, k), 32'(busy),
                  32'(exp_hit ? (k <= 34) : (k == 1)));
            check($sformatf("done y%0d c%0d", ly, k), 32'(done),
                  32'(k == (exp_hit ? 35 : 2)));
        end
    endtask

    task automatic query(input logic [9:0] dx, input logic eh, input logic [23:0] eo);
        draw_x = dx;
        @(negedge clk);
        check($sformatf("hit x%0d", dx), 32'(pixel_hit), 32'(eh));
        check($sformatf("out x%0d", dx), 32'(pixel_out), 32'(eo));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; line_y = '0; sprite_x = '0; sprite_y = '0;
        flip_x = 1'b0; draw_x = '0;
        repeat (3) @(negedge clk);
        check("rst addr", 32'(rom_read_address), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst out",  32'(pixel_out), 32'd0);
        check("rst hit",  32'(pixel_hit), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        query(10'd200, 1'b0, 24'd0);

        // Row 5: addresses 160..191, readback at sprite_x 200.
        run_fetch(10'd105, 10'd100, 10'd200, 1'b0, 1'b1, 0);
        for (int i = 0; i < 32; i++)
            query(10'(200 + i), 1'b1, 24'(160 + i));
        query(10'd199, 1'b0, 24'd0);
        query(10'd232, 1'b0, 24'd0);

        // Flipped with word 170 transparent.
        zero_addr = 170;
        run_fetch(10'd105, 10'd100, 10'd200, 1'b1, 1'b1, 0);
        query(10'd200, 1'b1, 24'd191);
        query(10'd221, 1'b0, 24'd0);
        query(10'd231, 1'b1, 24'd160);
        query(10'd222, 1'b1, 24'd169);
        zero_addr = -1;

        // Misses above, below and across the wrap.
        run_fetch(10'd99, 10'd100, 10'd200, 1'b0, 1'b0, 0);
        query(10'd200, 1'b0, 24'd0);
        query(10'd215, 1'b0, 24'd0);
        run_fetch(10'd132, 10'd100, 10'd200, 1'b0, 1'b0, 0);
        query(10'd210, 1'b0, 24'd0);
        run_fetch(10'd5, 10'd1000, 10'd200, 1'b0, 1'b0, 0);
        query(10'd200, 1'b0, 24'd0);

        // Last row of the sprite.
        run_fetch(10'd131, 10'd100, 10'd50, 1'b0, 1'b1, 0);
        query(10'd50, 1'b1, 24'd992);
        query(10'd81, 1'b1, 24'd1023);
        query(10'd82, 1'b0, 24'd0);

        // Re-pulsed start mid-fetch is ignored; row 10 completes on time.
        run_fetch(10'd110, 10'd100, 10'd200, 1'b0, 1'b1, 20);
        query(10'd205, 1'b1, 24'd325);

        // Reset at cycle 10 of a fetch aborts with no done.
        draw_x = 10'd200; line_y = 10'd120; sprite_y = 10'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-abort busy", 32'(busy), 32'd1);
        check("pre-abort hit",  32'(pixel_hit), 32'd1);
        check("pre-abort out",  32'(pixel_out), 32'd320);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort hit",  32'(pixel_hit), 32'd0);
        check("abort out",  32'(pixel_out), 32'd0);
        check("abort addr", 32'(rom_read_address), 32'd0);
        check("abort done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check($sformatf("post-abort done %0d", k), 32'(done), 32'd0);
            check($sformatf("post-abort busy %0d", k), 32'(busy), 32'd0);
        end
        query(10'd200, 1'b0, 24'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
